aec_feeder: RTL and testbench

- Upstream front end for the arithmetic expression calculator (AEC).
- Accepts expression characters from a host over a valid/ready byte stream and buffers one full expression, up to and including '='.
- Checks the character set, parenthesis balance and length, then replays the expression to AEC in AEC's burst protocol.
- Captures AEC's result and returns it to the host. Malformed expressions never reach AEC.

---
 rtl/aec_pkg.sv | 46 ++++
 rtl/aec_feeder_if.sv | 28 ++
 rtl/aec_char_check.sv | 18 +
 rtl/aec_feeder.sv | 203 ++++++++++++++++++++
 tb/tb_aec_feeder.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aec_pkg.sv
// Shared definitions for the AEC feeder and the AEC core: character set,
// feeder state encoding, classifier payload and the legal-character test.
package aec_pkg;

    localparam int unsigned AEC_MAX_LEN = 16;
    localparam int unsigned CHAR_W      = 8;
    localparam int unsigned RES_W       = 7;

    localparam logic [CHAR_W-1:0] ASCII_0      = 8'h30;
    localparam logic [CHAR_W-1:0] ASCII_9      = 8'h39;
    localparam logic [CHAR_W-1:0] ASCII_A      = 8'h61;
    localparam logic [CHAR_W-1:0] ASCII_F      = 8'h66;
    localparam logic [CHAR_W-1:0] ASCII_LPAREN = 8'h28;
    localparam logic [CHAR_W-1:0] ASCII_RPAREN = 8'h29;
    localparam logic [CHAR_W-1:0] ASCII_MUL    = 8'h2A;
    localparam logic [CHAR_W-1:0] ASCII_PLUS   = 8'h2B;
    localparam logic [CHAR_W-1:0] ASCII_MINUS  = 8'h2D;
    localparam logic [CHAR_W-1:0] ASCII_EQU    = 8'h3D;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_STREAM  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_REJECT  = 2'd3
    } state_t;

    typedef struct packed {
        logic legal;
        logic is_lparen;
        logic is_rparen;
        logic is_equ;
    } char_class_t;

    // True for digits, lowercase hex letters, parentheses, * + - and '='.
    function automatic logic is_legal_char(input logic [CHAR_W-1:0] c);
        logic digit;
        logic hex;
        digit = (c >= ASCII_0) && (c <= ASCII_9);
        hex   = (c >= ASCII_A) && (c <= ASCII_F);
        return digit || hex ||
               (c == ASCII_LPAREN) || (c == ASCII_RPAREN) ||
               (c == ASCII_MUL) || (c == ASCII_PLUS) ||
               (c == ASCII_MINUS) || (c == ASCII_EQU);
    endfunction

endpackage

// File: rtl/aec_feeder_if.sv
// Host byte stream, AEC burst port and result return of the AEC feeder.
// master: host/AEC environment side; slave: the feeder.
interface aec_feeder_if;
    import aec_pkg::*;

    logic              in_valid;
    logic [CHAR_W-1:0] in_char;
    logic              in_ready;
    logic              aec_ready;
    logic [CHAR_W-1:0] aec_ascii;
    logic              aec_valid;
    logic [RES_W-1:0]  aec_result;
    logic              res_valid;
    logic [RES_W-1:0]  res_data;
    logic              err;
    logic              busy;

    modport master (
        output in_valid, in_char, aec_valid, aec_result,
        input  in_ready, aec_ready, aec_ascii, res_valid, res_data, err, busy
    );

    modport slave (
        input  in_valid, in_char, aec_valid, aec_result,
        output in_ready, aec_ready, aec_ascii, res_valid, res_data, err, busy
    );

endinterface

// File: rtl/aec_char_check.sv
// Combinational classifier for one host character.
module aec_char_check
    import aec_pkg::*;
(
    input  logic [CHAR_W-1:0] in_char,
    output char_class_t       cls_c
);

    // Decode legality and the structurally significant characters.
    always_comb begin
        cls_c           = '0;
        cls_c.legal     = is_legal_char(in_char);
        cls_c.is_lparen = (in_char == ASCII_LPAREN);
        cls_c.is_rparen = (in_char == ASCII_RPAREN);
        cls_c.is_equ    = (in_char == ASCII_EQU);
    end

endmodule

// File: rtl/aec_feeder.sv
// AEC feeder: buffers one host expression up to '=', validates it, replays
// it to AEC as a gapless burst and returns AEC's result to the host.
// Optional macro AEC_FEEDER_TIMEOUT_EN adds a result-wait watchdog.
module aec_feeder
    import aec_pkg::*;
#(
    parameter int unsigned MAX_LEN = AEC_MAX_LEN
`ifdef AEC_FEEDER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic         clk,
    input  logic         rst,
    aec_feeder_if.slave  bus
);

    localparam int unsigned PTR_W   = $clog2(AEC_MAX_LEN);
    localparam int unsigned DEPTH_W = PTR_W + 1;

    state_t              state;
    state_t              state_next;
    char_class_t         cls_c;

    logic [CHAR_W-1:0]   char_buf [MAX_LEN];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    rd_ptr_d;
    logic [DEPTH_W-1:0]  depth;
    logic                bad_flag;

    logic                accept_c;
    logic                overflow_c;
    logic                bad_c;
    logic                store_c;
    logic                timeout_c;

    logic                in_ready_q,  in_ready_d;
    logic                aec_ready_q, aec_ready_d;
    logic [CHAR_W-1:0]   aec_ascii_q, aec_ascii_d;
    logic                res_valid_q, res_valid_d;
    logic [RES_W-1:0]    res_data_q,  res_data_d;
    logic                err_q,       err_d;
    logic                busy_q,      busy_d;

    aec_char_check u_char_check (
        .in_char (bus.in_char),
        .cls_c   (cls_c)
    );

    // Qualify the host character against the expression collected so far.
    always_comb begin
        accept_c   = bus.in_valid && in_ready_q && (state == ST_COLLECT);
        overflow_c = !cls_c.is_equ && (wr_ptr == PTR_W'(MAX_LEN - 1));
        bad_c      = !cls_c.legal || (cls_c.is_rparen && (depth == '0)) || overflow_c;
        store_c    = accept_c && !bad_flag && !bad_c;
    end

`ifdef AEC_FEEDER_TIMEOUT_EN
    logic [7:0] wd_cnt;

    // Watchdog counts cycles spent waiting on AEC; cleared outside WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if ((state == ST_WAIT) && (state_next == ST_WAIT)) begin
            wd_cnt <= wd_cnt + 8'(1);
        end else begin
            wd_cnt <= '0;
        end
    end

    assign timeout_c = (state == ST_WAIT) && !bus.aec_valid &&
                       (wd_cnt == 8'(TIMEOUT_CYC - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; '=' decides between replaying and rejecting.
    always_comb begin
        state_next = state;
        case (state)
            ST_COLLECT: begin
                if (accept_c && cls_c.is_equ) begin
                    if (bad_flag || (depth != '0) || (wr_ptr == '0)) begin
                        state_next = ST_REJECT;
                    end else begin
                        state_next = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (rd_ptr == wr_ptr) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.aec_valid || timeout_c) begin
                    state_next = ST_COLLECT;
                end
            end
            ST_REJECT: begin
                state_next = ST_COLLECT;
            end
            default: begin
                state_next = ST_COLLECT;
            end
        endcase
    end

    // Next values of the registered outputs, aligned with the next state.
    always_comb begin
        rd_ptr_d    = (state == ST_STREAM) ? rd_ptr + PTR_W'(1) : '0;
        in_ready_d  = (state_next == ST_COLLECT);
        busy_d      = (state_next != ST_COLLECT);
        aec_ready_d = (state == ST_COLLECT) && (state_next == ST_STREAM);
        aec_ascii_d = '0;
        if (state_next == ST_STREAM) begin
            aec_ascii_d = char_buf[rd_ptr_d];
        end
        res_valid_d = (state == ST_WAIT) && bus.aec_valid;
        res_data_d  = res_data_q;
        if (res_valid_d) begin
            res_data_d = bus.aec_result;
        end
        err_d = (state_next == ST_REJECT) || timeout_c;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_q  <= 1'b0;
            aec_ready_q <= 1'b0;
            aec_ascii_q <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            aec_ready_q <= aec_ready_d;
            aec_ascii_q <= aec_ascii_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    // Pointers, paren depth and sticky error; cleared once the expression ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            depth    <= '0;
            bad_flag <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr_d;
            if ((state == ST_WAIT) || (state == ST_REJECT)) begin
                wr_ptr   <= '0;
                depth    <= '0;
                bad_flag <= 1'b0;
            end else if (accept_c && !cls_c.is_equ) begin
                if (bad_c) begin
                    bad_flag <= 1'b1;
                end
                if (store_c) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    if (cls_c.is_lparen) begin
                        depth <= depth + DEPTH_W'(1);
                    end else if (cls_c.is_rparen) begin
                        depth <= depth - DEPTH_W'(1);
                    end
                end
            end
        end
    end

    // Expression storage; '=' lands at wr_ptr without advancing it.
    always_ff @(posedge clk) begin
        if (store_c) begin
            char_buf[wr_ptr] <= bus.in_char;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.aec_ready = aec_ready_q;
    assign bus.aec_ascii = aec_ascii_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aec_feeder.sv
// Self-checking bench for aec_feeder with a simple AEC responder model.
module tb_aec_feeder;
    import aec_pkg::*;

`ifdef AEC_FEEDER_TIMEOUT_EN
    localparam int unsigned TIMEOUT = 255;
`endif

    logic clk = 1'b0;
    logic rst;

    aec_feeder_if bus();

    aec_feeder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_chars[$];
    logic [6:0] exp_res[$];

    task automatic send_char(input logic [7:0] c);
        int unsigned t = 0;
        bus.in_char  = c;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_char: in_ready=%b after %0d cycles, required 1", bus.in_ready, t);
        end else begin
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
    endtask

    task automatic send_expr(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
            if (i < s.len() - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic push_stream(input string s);
        for (int i = 0; i < s.len(); i++) exp_chars.push_back(s[i]);
    endtask

    // Check the burst to AEC, answer it after 'delay' cycles, check the result.
    task automatic run_aec(input logic [6:0] result, input int unsigned delay, input string tag);
        bit          streaming = 1'b0;
        bit          after_eq  = 1'b0;
        bit          done      = 1'b0;
        bit          armed     = 1'b0;
        int unsigned cd        = 0;
        int unsigned ready_cnt = 0;
        int          ready_at  = -1;
        int unsigned err_cnt   = 0;
        int unsigned inr_cnt   = 0;
        logic [7:0]  e;
        logic [6:0]  r = 7'h0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (bus.err) err_cnt++;
            if (bus.aec_ready) begin
                ready_cnt++;
                if (ready_at < 0) ready_at = cyc;
                streaming = 1'b1;
            end
            if (streaming) begin
                if (bus.in_ready) inr_cnt++;
                n_checks++;
                if (exp_chars.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s stream_extra: aec_ascii=%h, required no character", tag, bus.aec_ascii);
                    streaming = 1'b0;
                end else begin
                    e = exp_chars.pop_front();
                    if (bus.aec_ascii !== e) begin
                        n_fail++;
                        $display("FAIL %s stream_char: aec_ascii=%h, required %h", tag, bus.aec_ascii, e);
                    end
                    if (e == ASCII_EQU) begin
                        streaming = 1'b0;
                        after_eq  = 1'b1;
                        armed     = 1'b1;
                        cd        = delay;
                    end
                end
            end else if (after_eq) begin
                after_eq = 1'b0;
                n_checks++;
                if (bus.aec_ascii !== 8'h00) begin
                    n_fail++;
                    $display("FAIL %s ascii_idle: aec_ascii=%h, required 00", tag, bus.aec_ascii);
                end
            end
            if (bus.res_valid) begin
                done = 1'b1;
                n_checks++;
                if (exp_res.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s res_extra: res_data=%0d, required no result", tag, bus.res_data);
                end else begin
                    r = exp_res.pop_front();
                    if (bus.res_data !== r) begin
                        n_fail++;
                        $display("FAIL %s res_data: got %0d, required %0d", tag, bus.res_data, r);
                    end
                end
            end
            bus.aec_valid = 1'b0;
            if (armed) begin
                if (cd == 0) begin
                    bus.aec_valid  = 1'b1;
                    bus.aec_result = result;
                    armed          = 1'b0;
                end else begin
                    cd--;
                end
            end
            if (!done) @(negedge clk);
        end
        bus.aec_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s res_timeout: res_valid=0 after 400 cycles, required 1", tag);
        end
        n_checks++;
        if (ready_cnt != 1 || ready_at != 0) begin
            n_fail++;
            $display("FAIL %s aec_ready: %0d cycles starting at %0d, required 1 at 0", tag, ready_cnt, ready_at);
        end
        n_checks++;
        if (err_cnt != 0 || inr_cnt != 0) begin
            n_fail++;
            $display("FAIL %s quiet: err cycles=%0d in_ready stream cycles=%0d, required 0 and 0", tag, err_cnt, inr_cnt);
        end
        n_checks++;
        if (exp_chars.size() != 0) begin
            n_fail++;
            $display("FAIL %s stream_short: %0d characters missing, required 0", tag, exp_chars.size());
        end
        exp_chars.delete();
        if (done) begin
            @(negedge clk);
            n_checks++;
            if (bus.res_valid !== 1'b0 || bus.res_data !== r) begin
                n_fail++;
                $display("FAIL %s res_hold: res_valid=%b res_data=%0d, required 0 and %0d", tag, bus.res_valid, bus.res_data, r);
            end
        end
    endtask

    // After '=' of a malformed expression: err one cycle later, AEC untouched.
    task automatic expect_reject(input string tag);
        int          seen_at   = -1;
        int unsigned err_cnt   = 0;
        int unsigned aec_cnt   = 0;
        int unsigned res_cnt   = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (bus.err) begin
                err_cnt++;
                if (seen_at < 0) seen_at = cyc;
            end
            if (bus.aec_ready || bus.aec_ascii != 8'h00) aec_cnt++;
            if (bus.res_valid) res_cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (seen_at != 0 || err_cnt != 1) begin
            n_fail++;
            $display("FAIL %s err: %0d cycles starting at %0d, required 1 at 0", tag, err_cnt, seen_at);
        end
        n_checks++;
        if (aec_cnt != 0 || res_cnt != 0) begin
            n_fail++;
            $display("FAIL %s aec_quiet: aec cycles=%0d res cycles=%0d, required 0 and 0", tag, aec_cnt, res_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.aec_ready, bus.res_valid, bus.err, bus.busy} !== 5'b0 ||
            bus.aec_ascii !== 8'h00 || bus.res_data !== 7'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b aec_rdy=%b ascii=%h rv=%b rd=%0d err=%b busy=%b, required all 0",
                     bus.in_ready, bus.aec_ready, bus.aec_ascii, bus.res_valid, bus.res_data, bus.err, bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b busy=%b, required 1 and 0", bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_basic();
        push_stream("3+4=");
        exp_res.push_back(7'd7);
        send_expr("3+4=", 0);
        run_aec(7'd7, 2, "basic");
    endtask

    task automatic test_gaps();
        push_stream("(2+3)*4=");
        exp_res.push_back(7'd20);
        send_expr("(2+3)*4=", 2);
        run_aec(7'd20, 1, "gaps");
    endtask

    task automatic test_illegal();
        send_expr("1+g=", 0);
        expect_reject("illegal");
        push_stream("9-1=");
        exp_res.push_back(7'd8);
        send_expr("9-1=", 0);
        run_aec(7'd8, 3, "after_reject");
    endtask

    task automatic test_structure();
        send_expr("(1+2=", 0);
        expect_reject("open_paren");
        send_expr(")1(=", 1);
        expect_reject("early_rparen");
        send_expr("=", 0);
        expect_reject("bare_equ");
    endtask

    task automatic test_overflow();
        send_expr("1+1+1+1+1+1+1+1+=", 0);
        expect_reject("overflow");
        push_stream("1+1+1+1+1+1+1+1=");
        exp_res.push_back(7'd8);
        send_expr("1+1+1+1+1+1+1+1=", 0);
        run_aec(7'd8, 2, "full_length");
    endtask

    task automatic test_ignore();
        int unsigned res_cnt = 0;
        bus.aec_valid  = 1'b1;
        bus.aec_result = 7'd55;
        repeat (3) begin
            @(negedge clk);
            if (bus.res_valid) res_cnt++;
        end
        bus.aec_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (res_cnt != 0 || bus.busy !== 1'b0 || bus.res_data !== 7'd8) begin
            n_fail++;
            $display("FAIL ignore_valid: res cycles=%0d busy=%b res_data=%0d, required 0, 0, 8", res_cnt, bus.busy, bus.res_data);
        end
    endtask

    task automatic test_reset_mid_stream();
        send_expr("1+2+3=", 0);
        n_checks++;
        if (bus.aec_ready !== 1'b1 || bus.aec_ascii !== 8'h31) begin
            n_fail++;
            $display("FAIL mid_stream_start: aec_ready=%b aec_ascii=%h, required 1 and 31", bus.aec_ready, bus.aec_ascii);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (bus.aec_ready !== 1'b0 || bus.aec_ascii !== 8'h00 || bus.busy !== 1'b0 ||
            bus.in_ready !== 1'b0 || bus.res_data !== 7'h00) begin
            n_fail++;
            $display("FAIL async_reset: aec_ready=%b ascii=%h busy=%b in_ready=%b res_data=%0d, required all 0",
                     bus.aec_ready, bus.aec_ascii, bus.busy, bus.in_ready, bus.res_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_recover: in_ready=%b, required 1", bus.in_ready);
        end
        push_stream("5+5=");
        exp_res.push_back(7'd10);
        send_expr("5+5=", 0);
        run_aec(7'd10, 2, "post_reset");
    endtask

`ifdef AEC_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        int          idx     = -1;
        bit          seen    = 1'b0;
        int unsigned res_cnt = 0;
        send_expr("2+2=", 0);
        for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
            if (bus.res_valid) res_cnt++;
            if (bus.err) begin
                seen = 1'b1;
                idx  = cyc;
            end else begin
                @(negedge clk);
            end
        end
        n_checks++;
        if (!seen || idx != 4 + int'(TIMEOUT)) begin
            n_fail++;
            $display("FAIL timeout_err: err at cycle %0d (seen=%b), required %0d", idx, seen, 4 + int'(TIMEOUT));
        end
        n_checks++;
        if (res_cnt != 0) begin
            n_fail++;
            $display("FAIL timeout_res: res_valid cycles=%0d, required 0", res_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_return: err=%b busy=%b in_ready=%b, required 0, 0, 1", bus.err, bus.busy, bus.in_ready);
        end
    endtask
`else
    task automatic test_long_wait();
        push_stream("2+2=");
        exp_res.push_back(7'd4);
        send_expr("2+2=", 0);
        run_aec(7'd4, 300, "long_wait");
    endtask
`endif

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_char    = 8'h00;
        bus.aec_valid  = 1'b0;
        bus.aec_result = 7'h00;
        rst            = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_gaps();
        test_illegal();
        test_structure();
        test_overflow();
        test_ignore();
        test_reset_mid_stream();
`ifdef AEC_FEEDER_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
